// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and operand-sign helpers for muldiv_unit
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  function automatic logic is_rem(input logic [2:0] op);
    return op == OP_REM || op == OP_REMU;
  endfunction
  function automatic logic is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_DIVU || is_rem(op);
  endfunction
  function automatic logic is_mul_high(input logic [2:0] op);
    return op == OP_MULH || op == OP_MULHSU || op == OP_MULHU;
  endfunction
  function automatic logic is_signed_a(input logic [2:0] op);
    return op == OP_DIV || op == OP_REM || op == OP_MULH || op == OP_MULHSU;
  endfunction
  function automatic logic is_signed_b(input logic [2:0] op);
    return op == OP_DIV || op == OP_REM || op == OP_MULH;
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or restoring shift-subtract (divide) iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opd,
  output logic [XLEN-1:0] hi_n,
  output logic [XLEN-1:0] lo_n
);
  logic [XLEN:0] sum, sh, diff;
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    sh   = {hi, lo[XLEN-1]};
    diff = sh - {1'b0, opd};
    hi_n = div_mode ? (diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
    lo_n = div_mode ? {lo[XLEN-2:0], !diff[XLEN]} : {sum[0], lo[XLEN-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready request and result handshakes
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] SRC_A,
  input  logic [XLEN-1:0] SRC_B,
  input  logic [4:0]      TAG_IN,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      TAG_OUT,
  output logic            BUSY
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  state_t state, state_n;
  logic [2:0] op_q;
  logic [XLEN-1:0] a_q, b_q, hi, lo, opd, mag_a, mag_b, spec_res, quo, rem_v, fix_res;
  logic [4:0] tag_q;
  logic [CW-1:0] cnt;
  logic neg_q, sa_q, sa, sb, dz, ovf, special;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] hi_c [UNROLL+1];
  logic [XLEN-1:0] lo_c [UNROLL+1];
  assign hi_c[0] = hi;
  assign lo_c[0] = lo;
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div_mode(is_div(op_q)),
      .hi(hi_c[i]),
      .lo(lo_c[i]),
      .opd(opd),
      .hi_n(hi_c[i+1]),
      .lo_n(lo_c[i+1])
    );
  end
  assign IN_READY  = state == IDLE;
  assign BUSY      = state != IDLE;
  assign OUT_VALID = state == DONE;
  assign TAG_OUT   = tag_q;
  always_comb begin
    sa       = is_signed_a(op_q) && a_q[XLEN-1];
    sb       = is_signed_b(op_q) && b_q[XLEN-1];
    mag_a    = sa ? -a_q : a_q;
    mag_b    = sb ? -b_q : b_q;
    dz       = b_q == '0;
    ovf      = is_signed_b(op_q) && a_q == {1'b1, {(XLEN-1){1'b0}}} && &b_q;
    special  = is_div(op_q) && (dz || ovf);
    spec_res = is_rem(op_q) ? (dz ? a_q : '0) : (dz ? '1 : a_q);
    prod     = neg_q ? -{hi, lo} : {hi, lo};
    quo      = neg_q ? -lo : lo;
    rem_v    = sa_q ? -hi : hi;
    fix_res  = is_div(op_q) ? (is_rem(op_q) ? rem_v : quo)
             : (op_q == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    state_n  = state;
    if (FLUSH) state_n = IDLE;
    else
      unique case (state)
        IDLE:    state_n = IN_VALID ? PREP : IDLE;
        PREP:    state_n = special ? DONE : CALC;
        CALC:    state_n = cnt == CW'(1) ? FIX : CALC;
        FIX:     state_n = DONE;
        DONE:    state_n = OUT_READY ? IDLE : DONE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) state <= IDLE;
    else state <= state_n;
  // Sign handling is deferred: CALC works on magnitudes, FIX restores signs.
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      hi     <= '0;
      lo     <= '0;
      opd    <= '0;
      neg_q  <= 1'b0;
      sa_q   <= 1'b0;
      cnt    <= '0;
      RESULT <= '0;
    end else begin
      if (state == IDLE && IN_VALID) begin
        op_q  <= OP;
        a_q   <= SRC_A;
        b_q   <= SRC_B;
        tag_q <= TAG_IN;
      end
      if (state == PREP) begin
        hi    <= '0;
        lo    <= mag_a;
        opd   <= mag_b;
        neg_q <= sa ^ sb;
        sa_q  <= sa;
        cnt   <= CW'(N);
        if (special) RESULT <= spec_res;
      end
      if (state == CALC) begin
        hi  <= hi_c[UNROLL];
        lo  <= lo_c[UNROLL];
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) RESULT <= fix_res;
    end
  logic unused_mulh;
  assign unused_mulh = is_mul_high(op_q);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed checks of muldiv_unit (UNROLL 1 and 4) against an arithmetic model
module tb_muldiv_unit;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [1:0] iv;
  logic [2:0] op;
  logic [31:0] a, b;
  logic [4:0] tag;
  logic FLUSH, out_ready;
  logic [1:0] rdy, ov, busy;
  logic [1:0][31:0] res;
  logic [1:0][4:0] tgo;
  int passed = 0, total = 0, cyc = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;
  muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (
    .CLK(CLK), .RESET(RESET), .IN_VALID(iv[0]), .IN_READY(rdy[0]), .OP(op), .SRC_A(a), .SRC_B(b),
    .TAG_IN(tag), .FLUSH(FLUSH), .OUT_VALID(ov[0]), .OUT_READY(out_ready), .RESULT(res[0]),
    .TAG_OUT(tgo[0]), .BUSY(busy[0]));
  muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (
    .CLK(CLK), .RESET(RESET), .IN_VALID(iv[1]), .IN_READY(rdy[1]), .OP(op), .SRC_A(a), .SRC_B(b),
    .TAG_IN(tag), .FLUSH(FLUSH), .OUT_VALID(ov[1]), .OUT_READY(out_ready), .RESULT(res[1]),
    .TAG_OUT(tgo[1]), .BUSY(busy[1]));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] ux, uy, p;
    logic ovf;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    ovf = x == 32'h80000000 && y == 32'hFFFFFFFF;
    model = '0;
    case (o)
      3'd0: begin p = ux * uy; model = p[31:0]; end
      3'd1: begin p = 64'(sx * sy); model = p[63:32]; end
      3'd2: begin p = 64'(sx) * uy; model = p[63:32]; end
      3'd3: begin p = ux * uy; model = p[63:32]; end
      3'd4: if (y == 0) model = '1; else if (ovf) model = x; else model = 32'($signed(x) / $signed(y));
      3'd5: model = (y == 0) ? '1 : x / y;
      3'd6: if (y == 0) model = x; else if (ovf) model = '0; else model = 32'($signed(x) % $signed(y));
      default: model = (y == 0) ? x : x % y;
    endcase
  endfunction
  function automatic logic special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
  endfunction
  logic pend [2];
  logic ichk [2];
  logic [31:0] er [2];
  logic [4:0] et [2];
  int el [2], ac [2];
  initial for (int i = 0; i < 2; i++) begin pend[i] = 0; ichk[i] = 0; end
  always @(negedge CLK)
    for (int i = 0; i < 2; i++) begin
      if (!RESET) begin
        pend[i] = 0;
        ichk[i] = 0;
        chk("reset_outputs", 64'({ov[i], busy[i], rdy[i], res[i], tgo[i]}), 64'({3'b001, 37'b0}));
      end else begin
        if (ichk[i]) begin
          chk("flush_idle", 64'({rdy[i], ov[i], busy[i]}), 64'(3'b100));
          ichk[i] = 0;
        end
        if (pend[i]) begin
          if (cyc - ac[i] < el[i]) chk("in_flight", 64'({ov[i], rdy[i], busy[i]}), 64'(3'b001));
          else chk("result", 64'({ov[i], busy[i], res[i], tgo[i]}), 64'({2'b11, er[i], et[i]}));
          if (FLUSH) begin pend[i] = 0; ichk[i] = 1; end
          else if (ov[i] && out_ready) pend[i] = 0;
        end else chk("no_spurious_valid", 64'(ov[i]), 64'(0));
        if (!pend[i] && !FLUSH && iv[i] && rdy[i]) begin
          pend[i] = 1;
          er[i] = model(op, a, b);
          et[i] = tag;
          ac[i] = cyc;
          el[i] = special(op, a, b) ? 2 : (i == 0 ? 35 : 11);
        end
      end
    end
  task automatic issue(input int s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t, output int w);
    op = o; a = x; b = y; tag = t; iv[s] = 1'b1; w = 0;
    do begin @(negedge CLK); w++; end while (!rdy[s] && w < 100);
    if (!rdy[s]) chk("accept_timeout", 64'(rdy[s]), 64'(1));
    @(posedge CLK); #1;
    iv[s] = 1'b0;
  endtask
  task automatic wait_res(input int s, input logic [31:0] exp, input int lat, input logic [4:0] t);
    int n = 0;
    do begin @(negedge CLK); n++; end while (!ov[s] && n < 200);
    chk("latency", 64'(n), 64'(lat));
    chk("result_literal", 64'(res[s]), 64'(exp));
    chk("tag_literal", 64'(tgo[s]), 64'(t));
    @(posedge CLK); #1;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction
  typedef struct packed {logic [2:0] o; logic [31:0] x, y, e;} vec_t;
  vec_t vecs [12] = '{
    '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB},
    '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000},
    '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE},
    '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF},
    '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD},
    '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF},
    '{3'd5, 32'd100,        32'd7,        32'd14},
    '{3'd7, 32'd100,        32'd7,        32'd2},
    '{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF},
    '{3'd7, 32'd5,          32'd0,        32'd5},
    '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000},
    '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'h0}};
  initial begin
    int w, n;
    logic done;
    iv = '0; op = '0; a = '0; b = '0; tag = '0; FLUSH = 1'b0; out_ready = 1'b1;
    #1 RESET = 1'b0;
    #1 chk("reset_state", 64'({ov, busy, rdy, res[0], tgo[0]}), 64'({6'b000011, 37'b0}));
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 12; k++) begin
        issue(s, vecs[k].o, vecs[k].x, vecs[k].y, 5'(k + 5), w);
        wait_res(s, vecs[k].e, k >= 8 ? 2 : (s == 0 ? 35 : 11), 5'(k + 5));
      end
    out_ready = 1'b0;
    issue(0, 3'd5, 32'd100, 32'd7, 5'd9, w);
    n = 0;
    do begin @(negedge CLK); n++; end while (!ov[0] && n < 200);
    chk("hold_latency", 64'(n), 64'(35));
    repeat (10) begin
      @(negedge CLK);
      chk("hold_result", 64'(res[0]), 64'(14));
      chk("hold_tag", 64'(tgo[0]), 64'(9));
      chk("hold_in_ready", 64'({ov[0], rdy[0]}), 64'(2'b10));
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    issue(0, 3'd0, 32'd3, 32'd5, 5'd10, w);
    chk("b2b_accept", 64'(w), 64'(2));
    wait_res(0, 32'd15, 35, 5'd10);
    issue(0, 3'd0, 32'd6, 32'd7, 5'd11, w);
    repeat (10) @(posedge CLK);
    #1 FLUSH = 1'b1;
    @(posedge CLK); #1 FLUSH = 1'b0;
    chk("flush_idle_now", 64'({rdy[0], ov[0], busy[0]}), 64'(3'b100));
    repeat (40) @(negedge CLK);
    issue(0, 3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd12, w);
    repeat (5) @(posedge CLK);
    #2 RESET = 1'b0;
    #1 chk("async_reset", 64'({ov[0], busy[0], rdy[0], res[0], tgo[0]}), 64'({3'b001, 37'b0}));
    @(posedge CLK); #1 RESET = 1'b1;
    issue(0, 3'd0, 32'd3, 32'd4, 5'd13, w);
    wait_res(0, 32'd12, 35, 5'd13);
    for (int s = 0; s < 2; s++)
      repeat (s == 0 ? 30 : 20) begin
        issue(s, 3'($urandom), pick(), pick(), 5'($urandom), w);
        n = 0;
        do begin
          out_ready = 1'($urandom_range(0, 1));
          @(negedge CLK);
          done = ov[s] && out_ready;
          @(posedge CLK); #1;
          n++;
        end while (!done && n < 300);
        if (!done) chk("handshake_timeout", 64'(done), 64'(1));
        out_ready = 1'b1;
      end
    repeat (3) @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in operand width and bits retired per cycle. Sits beside the single-cycle ALU in the execute stage. Takes operands and a destination tag via a valid/ready handshake and returns one result via a second valid/ready handshake. Covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, including the RISC-V divide-by-zero and overflow rules.

## Interface
- XLEN, 32, operand/result width; even, ≥ 8
- UNROLL, 1, iterations per CALC cycle; must divide XLEN
- CLK  in  1  clock, all state on rising edge
- RESET  in  1  asynchronous, active-low; clears all state
- IN_VALID  in  1  request present
- IN_READY  out  1  unit can accept; high only in IDLE
- OP  in  3  f3 encoding: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- SRC_A  in  XLEN  rs1 / dividend
- SRC_B  in  XLEN  rs2 / divisor
- TAG_IN  in  5  rd address, carried through unchanged
- FLUSH  in  1  abort in-flight operation
- OUT_VALID  out  1  RESULT/TAG_OUT valid
- OUT_READY  in  1  consumer accepts result
- RESULT  out  XLEN  selected result
- TAG_OUT  out  5  tag of the request
- BUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE → PREP on IN_VALID && IN_READY. OP, SRC_A, SRC_B and TAG_IN are latched at that point.
- PREP: compute operand magnitudes. Signed operands are DIV/REM both, MULH both, MULHSU A only. Record result sign, load the iteration counter with XLEN/UNROLL, and detect special cases.
  - Divide by zero: quotient = all ones; remainder = SRC_A unmodified.
  - Signed overflow (SRC_A = 1 followed by zeros, SRC_B = all ones, DIV/REM): quotient = SRC_A; remainder = 0.
  - Special case: PREP → DONE directly, with RESULT loaded. Otherwise PREP → CALC.
- CALC: multiply runs shift-add into a 2·XLEN accumulator. Divide runs restoring shift-subtract into a quotient/remainder pair. Each cycle retires UNROLL bits; the counter decrements by 1. On counter = 1, CALC → FIX.
- FIX: apply sign.
  - Product: two's-complement negate of the 2·XLEN value if signs differ.
  - Quotient: negative if signs differ.
  - Remainder: takes the dividend's sign.
  - Select low half (MUL), high half (MULH*), quotient or remainder. FIX → DONE.
- DONE: OUT_VALID = 1. On OUT_READY → IDLE.
- FLUSH has priority over all transitions. From any state it forces IDLE on the next edge. OUT_VALID drops and the latched request is discarded.
- IN_VALID while not IDLE is ignored; the producer holds it.
- Arithmetic modulo 2^XLEN; no exceptions raised.

## Timing
- Reset values: state IDLE, OUT_VALID 0, BUSY 0, IN_READY 1, RESULT 0, TAG_OUT 0, counter 0.
- IN_READY is combinational from state only, with no path from IN_VALID.
- Let N = XLEN/UNROLL. For an accept on edge k:
  - PREP in cycle k+1.
  - CALC in cycles k+2 … k+N+1.
  - FIX in cycle k+N+2.
  - OUT_VALID high from cycle k+N+3.
- XLEN=32, UNROLL=1: 35 cycles accept-to-valid.
- Special cases: OUT_VALID from cycle k+2.
- RESULT and TAG_OUT are registered and stable while OUT_VALID && !OUT_READY.
- Minimum issue interval: next accept occurs one edge after the OUT_VALID && OUT_READY edge, i.e. N+4 cycles back-to-back.
- RESET low mid-operation clears immediately, regardless of CLK; no result is emitted.

## Structure
- Package muldiv_pkg holds:
  - OP encodings as localparams.
  - State enum (IDLE/PREP/CALC/FIX/DONE).
  - Helpers is_div(op) and is_signed_a/b(op).
- Sub-module muldiv_step: one combinational iteration, either shift-add or restoring subtract, selected by mode. It is instantiated UNROLL times in a chain inside muldiv_unit.
- The FSM, counter and registers live in muldiv_unit.

## Test plan
- MUL 7 × 0xFFFFFFFD, TAG_IN=5 → RESULT 0xFFFFFFEB, TAG_OUT 5, OUT_VALID exactly 35 cycles after accept, IN_READY low throughout.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIV 5 / 0 → 0xFFFFFFFF, REMU 5 / 0 → 5, DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM same operands → 0. All of these have OUT_VALID at k+2.
- OUT_READY held low 10 cycles in DONE → RESULT/TAG_OUT constant and IN_READY low. Second request accepted exactly one edge after the handshake. UNROLL=4 rerun gives 11-cycle latency with identical results.
- FLUSH in the 10th CALC cycle → IDLE next edge with no OUT_VALID. RESET pulsed low mid-CALC → all outputs at reset values immediately, then a fresh MUL 3 × 4 → 12.
